// File: rtl/link_slot_scheduler.sv
// Frame-slotted link scheduler: round-robin grants one requester per frame onto the
// link and routes each returned sample back to its owner LAT_FRAMES frames later.
module link_slot_scheduler #(
    parameter int unsigned FRAME_CYCLES = 720,
    parameter int unsigned LAT_FRAMES   = 2,
    parameter logic [7:0]  IDLE_WORD    = 8'h00
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic       sync_in,
    input  logic [1:0] req_valid,
    input  logic [7:0] req_data0,
    input  logic [7:0] req_data1,
    output logic [1:0] req_ready,
    output logic [7:0] link_ad,
    output logic       link_sync,
    input  logic [7:0] link_da,
    output logic       frame_strobe,
    output logic [1:0] rx_valid,
    output logic [7:0] rx_data
);

    localparam logic [0:0]  S_IDLE    = 1'b0;
    localparam logic [0:0]  S_RUN     = 1'b1;
    localparam logic [11:0] FCNT_LAST = 12'(FRAME_CYCLES - 1);

    logic [0:0]          state;
    logic [11:0]         fcnt;
    logic                rr_pri;
    logic [LAT_FRAMES:0] tag_v;
    logic [LAT_FRAMES:0] tag_id;
    logic                run_act;
    logic                frame_start;
    logic                frame_end;
    logic                win_vld;
    logic                win_id;

    // Dropping sync_in suppresses every RUN action in that same cycle.
    always_comb begin
        run_act     = (state == S_RUN) && sync_in;
        frame_start = run_act && (fcnt == '0);
        frame_end   = run_act && (fcnt == FCNT_LAST);
        win_vld     = |req_valid;
        win_id      = (&req_valid) ? rr_pri : req_valid[1];
        req_ready   = '0;
        if (frame_start && win_vld) begin
            req_ready = win_id ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state        <= S_IDLE;
            fcnt         <= '0;
            rr_pri       <= 1'b0;
            tag_v        <= '0;
            tag_id       <= '0;
            link_ad      <= IDLE_WORD;
            link_sync    <= 1'b0;
            frame_strobe <= 1'b0;
            rx_valid     <= '0;
            rx_data      <= '0;
        end else begin
            frame_strobe <= frame_start;
            link_sync    <= (state == S_RUN);
            rx_valid     <= '0;
            case (state)
                S_IDLE: begin
                    if (sync_in) begin
                        state <= S_RUN;
                        fcnt  <= '0;
                    end
                end
                S_RUN: begin
                    if (!sync_in) begin
                        state   <= S_IDLE;
                        fcnt    <= '0;
                        tag_v   <= '0;
                        link_ad <= IDLE_WORD;
                    end else begin
                        fcnt <= frame_end ? '0 : fcnt + 12'd1;
                        if (frame_start) begin
                            link_ad <= win_vld ? (win_id ? req_data1 : req_data0) : IDLE_WORD;
                            tag_v   <= {tag_v[LAT_FRAMES-1:0], win_vld};
                            tag_id  <= {tag_id[LAT_FRAMES-1:0], win_id};
                            if (win_vld) begin
                                rr_pri <= ~win_id;
                            end
                        end
                        // Oldest tag belongs to the frame whose sample is arriving now.
                        if (frame_end && tag_v[LAT_FRAMES]) begin
                            rx_valid <= tag_id[LAT_FRAMES] ? 2'b10 : 2'b01;
                            rx_data  <= link_da;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_link_slot_scheduler.sv
// Directed bench for link_slot_scheduler: a 720/2 instance and a 4/1 instance, each
// looped back through a fixed LAT_FRAMES*FRAME_CYCLES delay acting as the link.
module tb_link_slot_scheduler;

    typedef struct {
        logic [1:0] rv;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] gnt;
        logic [7:0] ad;
        logic [1:0] rxv;
        logic [7:0] rxd;
    } vec_t;

    localparam int DA = 1440;
    localparam int DB = 4;

    logic       clock, resetN, sync_a, sync_b, sel;
    logic [1:0] rv;
    logic [7:0] d0, d1;
    int         fc;
    int         n_tests = 0;
    int         n_fail  = 0;

    logic [1:0] req_ready_a, rx_valid_a, req_ready_b, rx_valid_b;
    logic [7:0] link_ad_a, rx_data_a, link_da_a, link_ad_b, rx_data_b, link_da_b;
    logic       link_sync_a, frame_strobe_a, link_sync_b, frame_strobe_b;

    logic [1:0] req_ready_m, rx_valid_m;
    logic [7:0] link_ad_m, rx_data_m;
    logic       link_sync_m, frame_strobe_m;

    logic [7:0] sr_a [0:DA-1];
    logic [7:0] sr_b [0:DB-1];

    link_slot_scheduler #(.FRAME_CYCLES(720), .LAT_FRAMES(2), .IDLE_WORD(8'h00)) dut_a (
        .clock(clock), .resetN(resetN), .sync_in(sync_a), .req_valid(rv),
        .req_data0(d0), .req_data1(d1), .req_ready(req_ready_a), .link_ad(link_ad_a),
        .link_sync(link_sync_a), .link_da(link_da_a), .frame_strobe(frame_strobe_a),
        .rx_valid(rx_valid_a), .rx_data(rx_data_a));

    link_slot_scheduler #(.FRAME_CYCLES(4), .LAT_FRAMES(1), .IDLE_WORD(8'h00)) dut_b (
        .clock(clock), .resetN(resetN), .sync_in(sync_b), .req_valid(rv),
        .req_data0(d0), .req_data1(d1), .req_ready(req_ready_b), .link_ad(link_ad_b),
        .link_sync(link_sync_b), .link_da(link_da_b), .frame_strobe(frame_strobe_b),
        .rx_valid(rx_valid_b), .rx_data(rx_data_b));

    always #5 clock = ~clock;

    // Link model: link_da in cycle c equals link_ad in cycle c - LAT_FRAMES*FRAME_CYCLES.
    always @(posedge clock) begin
        sr_a[0] <= link_ad_a;
        for (int i = 1; i < DA; i++) sr_a[i] <= sr_a[i-1];
        sr_b[0] <= link_ad_b;
        for (int j = 1; j < DB; j++) sr_b[j] <= sr_b[j-1];
    end
    assign link_da_a = sr_a[DA-1];
    assign link_da_b = sr_b[DB-1];

    assign req_ready_m    = sel ? req_ready_b    : req_ready_a;
    assign rx_valid_m     = sel ? rx_valid_b     : rx_valid_a;
    assign link_ad_m      = sel ? link_ad_b      : link_ad_a;
    assign rx_data_m      = sel ? rx_data_b      : rx_data_a;
    assign link_sync_m    = sel ? link_sync_b    : link_sync_a;
    assign frame_strobe_m = sel ? frame_strobe_b : frame_strobe_a;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Entered at the negedge of a frame-start cycle; returns at the next frame-start negedge.
    task automatic run_frame(input vec_t v);
        logic bad;
        rv = v.rv; d0 = v.d0; d1 = v.d1;
        #1;
        check("req_ready", {6'b0, req_ready_m}, {6'b0, v.gnt});
        check("rx_valid", {6'b0, rx_valid_m}, {6'b0, v.rxv});
        if (v.rxv != 2'b00) check("rx_data", rx_data_m, v.rxd);
        @(negedge clock); #1;
        check("frame_strobe", {7'b0, frame_strobe_m}, 8'h01);
        check("link_ad", link_ad_m, v.ad);
        check("link_sync", {7'b0, link_sync_m}, 8'h01);
        bad = 1'b0;
        for (int c = 2; c < fc; c++) begin
            @(negedge clock); #1;
            if (frame_strobe_m || rx_valid_m != 2'b00 || req_ready_m != 2'b00 || link_ad_m !== v.ad)
                bad = 1'b1;
        end
        check("frame_quiet", {7'b0, bad}, 8'h00);
        @(negedge clock);
    endtask

    vec_t tbl  [13];
    vec_t run2 [4];
    vec_t run3 [6];
    vec_t tblb [7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bad;
        //          rv     d0     d1     gnt    ad     rxv    rxd
        tbl[0]  = '{2'b01, 8'h20, 8'h00, 2'b01, 8'h20, 2'b00, 8'h00};
        tbl[1]  = '{2'b01, 8'h21, 8'h00, 2'b01, 8'h21, 2'b00, 8'h00};
        tbl[2]  = '{2'b00, 8'h22, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00};
        tbl[3]  = '{2'b01, 8'h23, 8'h00, 2'b01, 8'h23, 2'b01, 8'h20};
        tbl[4]  = '{2'b11, 8'h24, 8'hA4, 2'b10, 8'hA4, 2'b01, 8'h21};
        tbl[5]  = '{2'b11, 8'h25, 8'hA5, 2'b01, 8'h25, 2'b00, 8'h00};
        tbl[6]  = '{2'b11, 8'h26, 8'hA6, 2'b10, 8'hA6, 2'b01, 8'h23};
        tbl[7]  = '{2'b10, 8'h00, 8'hA7, 2'b10, 8'hA7, 2'b10, 8'hA4};
        tbl[8]  = '{2'b11, 8'h28, 8'hA8, 2'b01, 8'h28, 2'b01, 8'h25};
        tbl[9]  = '{2'b00, 8'h29, 8'hA9, 2'b00, 8'h00, 2'b10, 8'hA6};
        tbl[10] = '{2'b01, 8'h2A, 8'h00, 2'b01, 8'h2A, 2'b10, 8'hA7};
        tbl[11] = '{2'b01, 8'h2B, 8'h00, 2'b01, 8'h2B, 2'b01, 8'h28};
        tbl[12] = '{2'b01, 8'h2C, 8'h00, 2'b01, 8'h2C, 2'b00, 8'h00};
        // Restart after sync drop: round-robin pointer still favours requester 1.
        run2[0] = '{2'b11, 8'h70, 8'hB0, 2'b10, 8'hB0, 2'b00, 8'h00};
        run2[1] = '{2'b01, 8'h71, 8'h00, 2'b01, 8'h71, 2'b00, 8'h00};
        run2[2] = '{2'b01, 8'h72, 8'h00, 2'b01, 8'h72, 2'b00, 8'h00};
        run2[3] = '{2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 2'b10, 8'hB0};
        // After reset: requester 0 favoured again, no stale deliveries.
        run3[0] = '{2'b11, 8'h80, 8'hC0, 2'b01, 8'h80, 2'b00, 8'h00};
        run3[1] = '{2'b11, 8'h81, 8'hC1, 2'b10, 8'hC1, 2'b00, 8'h00};
        run3[2] = '{2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00};
        run3[3] = '{2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 2'b01, 8'h80};
        run3[4] = '{2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 2'b10, 8'hC1};
        run3[5] = '{2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00};
        // 4-cycle frames, 1-frame latency.
        tblb[0] = '{2'b01, 8'h10, 8'h00, 2'b01, 8'h10, 2'b00, 8'h00};
        tblb[1] = '{2'b11, 8'h11, 8'h91, 2'b10, 8'h91, 2'b00, 8'h00};
        tblb[2] = '{2'b11, 8'h12, 8'h92, 2'b01, 8'h12, 2'b01, 8'h10};
        tblb[3] = '{2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 2'b10, 8'h91};
        tblb[4] = '{2'b10, 8'h00, 8'h94, 2'b10, 8'h94, 2'b01, 8'h12};
        tblb[5] = '{2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00};
        tblb[6] = '{2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 2'b10, 8'h94};

        clock = 1'b0; resetN = 1'b0; sync_a = 1'b0; sync_b = 1'b0; sel = 1'b0; fc = 720;
        rv = 2'b00; d0 = 8'h00; d1 = 8'h00;

        repeat (3) @(negedge clock);
        #1;
        check("rst_link_ad", link_ad_a, 8'h00);
        check("rst_link_sync", {7'b0, link_sync_a}, 8'h00);
        check("rst_frame_strobe", {7'b0, frame_strobe_a}, 8'h00);
        check("rst_rx_valid", {6'b0, rx_valid_a}, 8'h00);
        check("rst_rx_data", rx_data_a, 8'h00);
        rv = 2'b11;
        #1;
        check("rst_req_ready", {6'b0, req_ready_a}, 8'h00);
        @(negedge clock);
        resetN = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        check("idle_req_ready", {6'b0, req_ready_a}, 8'h00);
        check("idle_link_sync", {7'b0, link_sync_a}, 8'h00);
        @(negedge clock);
        sync_a = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 13; i++) run_frame(tbl[i]);

        // Frame 13: deliver frame 10, then drop sync mid-frame with frames 11..13 in flight.
        rv = 2'b00;
        #1;
        check("rx_valid_f13", {6'b0, rx_valid_a}, 8'h01);
        check("rx_data_f13", rx_data_a, 8'h2A);
        repeat (300) @(negedge clock);
        sync_a = 1'b0;
        rv = 2'b11;
        bad = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clock); #1;
            if (rx_valid_a != 2'b00 || req_ready_a != 2'b00 || frame_strobe_a) bad = 1'b1;
            if (c == 3) begin
                check("drop_link_sync", {7'b0, link_sync_a}, 8'h00);
                check("drop_link_ad", link_ad_a, 8'h00);
            end
        end
        check("drop_quiet", {7'b0, bad}, 8'h00);
        @(negedge clock);
        sync_a = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 4; i++) run_frame(run2[i]);

        // Frame 4 of the restarted run; reset lands mid-frame with frames 2..4 in flight.
        rv = 2'b01; d0 = 8'h74;
        #1;
        check("rx_valid_r2f4", {6'b0, rx_valid_a}, 8'h01);
        check("rx_data_r2f4", rx_data_a, 8'h71);
        repeat (50) @(negedge clock);
        #1;
        check("pre_rst_link_ad", link_ad_a, 8'h74);
        resetN = 1'b0;
        #1;
        check("arst_link_ad", link_ad_a, 8'h00);
        check("arst_link_sync", {7'b0, link_sync_a}, 8'h00);
        check("arst_rx_data", rx_data_a, 8'h00);
        check("arst_req_ready", {6'b0, req_ready_a}, 8'h00);
        repeat (3) @(negedge clock);
        #1;
        check("hold_rst_rx_valid", {6'b0, rx_valid_a}, 8'h00);
        check("hold_rst_strobe", {7'b0, frame_strobe_a}, 8'h00);
        resetN = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 6; i++) run_frame(run3[i]);
        sync_a = 1'b0;
        repeat (5) @(negedge clock);

        sel = 1'b1; fc = 4;
        sync_b = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 7; i++) run_frame(tblb[i]);
        sync_b = 1'b0;
        repeat (3) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/link_slot_scheduler.md
LINK_SLOT_SCHEDULER -- requirements
Module: link_slot_scheduler

Interface
REQ-001 The block SHALL have parameter FRAME_CYCLES, default 720: clock cycles per link frame; legal range 4..4095.
REQ-002 The block SHALL have parameter LAT_FRAMES, default 2: link latency in frames from link_ad to link_da; legal range 1..7.
REQ-003 The block SHALL have parameter IDLE_WORD, default 8'h00: sample driven when no requester owns a frame.
REQ-004 Port clock, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port resetN, input, 1: asynchronous, active-low reset.
REQ-006 Port sync_in, input, 1: link-enable level; high means start or keep scheduling.
REQ-007 Port req_valid, input, 2: per-requester sample-pending flags.
REQ-008 Port req_data0 / req_data1, input, 8 each: requester samples.
REQ-009 Port req_ready, output, 2: one-hot grant pulse; data taken this cycle.
REQ-010 Port link_ad, output, 8: registered sample to the link sender, held for the whole frame.
REQ-011 Port link_sync, output, 1: registered sync to the link sender.
REQ-012 Port link_da, input, 8: sample returned by the link receiver.
REQ-013 Port frame_strobe, output, 1: registered one-cycle pulse at each frame start.
REQ-014 Port rx_valid, output, 2: registered one-hot pulse routing rx_data to its owner.
REQ-015 Port rx_data, output, 8: registered returned sample.

Function
REQ-016 FSM states SHALL be IDLE and RUN only; IDLE->RUN when sync_in=1; RUN->IDLE when sync_in=0, taking precedence over every other RUN action in that cycle.
REQ-017 In RUN, frame counter fcnt SHALL count 0..FRAME_CYCLES-1 and wrap to 0; fcnt=0 on the first RUN cycle.
REQ-018 "Frame start" means RUN and fcnt=0; "frame end" means RUN and fcnt=FRAME_CYCLES-1.
REQ-019 At frame start, arbitration SHALL be round-robin over req_valid: one valid requester wins; if both are valid, the one not granted most recently wins; after reset, requester 0 has priority.
REQ-020 req_ready SHALL be combinational, asserted only on a frame start cycle, only for the winner, and at most one bit at a time.
REQ-021 link_ad SHALL load the winner's data, or IDLE_WORD if no requester is valid, on the cycle after frame start, and hold it until the next frame start.
REQ-022 Owner-tag pipeline: LAT_FRAMES+1 entries of {valid, id}; at frame start, shift by one and insert the winner tag (valid=0 if no grant) at entry 0.
REQ-023 At frame end, the oldest tag (frame n-LAT_FRAMES relative to current frame n) SHALL be used; if it is valid, on the next cycle rx_valid[id]=1 for one cycle and rx_data=link_da sampled at frame end.
REQ-024 frame_strobe SHALL pulse for one cycle on the cycle after each frame start.
REQ-025 link_sync SHALL be 1 from the cycle after entering RUN, and 0 the cycle after leaving RUN.
REQ-026 On RUN->IDLE, the block SHALL clear all tag valids, set link_ad=IDLE_WORD, and emit no rx_valid for any frame in flight; the round-robin pointer is retained.
REQ-027 In IDLE, req_ready, rx_valid and frame_strobe SHALL be 0.
REQ-028 When sync_in returns high, the first RUN cycle SHALL be a frame start, and the first rx_valid SHALL occur no earlier than the end of frame LAT_FRAMES.

Reset
REQ-029 While resetN=0, asynchronously: state=IDLE, fcnt=0, tags invalid, RR priority=requester 0, link_ad=IDLE_WORD, link_sync=0, frame_strobe=0, rx_valid=0, rx_data=0.
REQ-030 Deassertion of resetN SHALL take effect at the first rising edge with resetN=1; reset asserted mid-RUN SHALL abort the frame with no rx_valid.

Verification (FRAME_CYCLES=720, LAT_FRAMES=2, link modelled as a 2-frame delay)
REQ-031 Single requester: sync_in=1, req_valid=01, req_data0=8'h20..8'h2F, one per frame -> link_ad steps once per 720 cycles; rx_valid=01 with rx_data=8'h20 at the end of frame 2, then ascending values with no gaps.
REQ-032 Contention: req_valid=11 held -> grants alternate 0,1,0,1 starting with 0; rx_valid alternates 01,10 starting 2 frames later; req_ready is never 11.
REQ-033 Idle frames: no req_valid in frame 1 -> link_ad=8'h00 in frame 1; no rx_valid 2 frames later; neighbouring frames deliver normally.
REQ-034 sync_in dropped mid-frame 3, raised 100 cycles later -> link_sync falls, no rx_valid for the frames in flight, fcnt restarts at 0, the first post-restart rx_valid comes 2 frames later.
REQ-035 resetN pulsed low for 3 cycles mid-frame -> all outputs reach their reset values immediately, with no stale rx_valid after release.
REQ-036 FRAME_CYCLES=4, LAT_FRAMES=1 -> frame_strobe period is 4 cycles, and each rx_valid follows its grant by exactly 1 frame.
